// File: rtl/bg_pkg.sv
// rtl/bg_pkg.sv - shared types and helpers for the background-object scheduler
package bg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } sched_state_t;

    localparam int CD_W = 5;

    // Full-resolution spawn position; callers keep the low 10-CONV bits.
    function automatic logic [9:0] spawn_pos_full(input logic [7:0] rng);
        return {5'b11111, rng[6:2]};
    endfunction

endpackage

// File: rtl/bg_slot.sv
// rtl/bg_slot.sv - one background-object slot: position/valid pair with scroll and retire
module bg_slot #(
    parameter int W     = 10,
    parameter int SPEED = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         scroll,
    input  logic         load,
    input  logic [W-1:0] load_pos,
    output logic [W-1:0] pos,
    output logic         valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos   <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            pos   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            pos   <= load_pos;
            valid <= 1'b1;
        end else if (scroll && valid) begin
            // A slot that cannot take a full step retires instead of wrapping.
            if (pos >= W'(SPEED)) begin
                pos <= pos - W'(SPEED);
            end else begin
                pos   <= '0;
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bg_object_scheduler.sv
// rtl/bg_object_scheduler.sv - spawns, scrolls and retires background objects on game_tick
module bg_object_scheduler
    import bg_pkg::*;
#(
    parameter int CONV    = 0,
    parameter int NSLOTS  = 3,
    parameter int MIN_GAP = 8,
    parameter int SPEED   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     game_tick,
    input  logic                     game_start,
    input  logic                     game_over,
    input  logic [7:0]               rng,
    output logic [NSLOTS*(10-CONV)-1:0] obj_pos,
    output logic [NSLOTS-1:0]        obj_valid,
    output logic                     spawn_pulse,
    output logic [1:0]               sched_state
);

    localparam int W = 10 - CONV;

    sched_state_t    state;
    logic [CD_W-1:0] cooldown;
    logic [CD_W-1:0] cd_reload;
    logic [9:0]      spawn_full;
    logic [W-1:0]    spawn_pos;
    logic            any_free;
    logic [1:0]      free_idx;
    logic            start_run;
    logic            tick_run;
    logic            spawn;
    logic            unused_rng;

    assign unused_rng = rng[7];

    // game_over wins over a coincident tick, so a frozen frame never moves.
    assign start_run  = game_start && (state != ST_RUN);
    assign tick_run   = game_tick && (state == ST_RUN) && !game_over;
    assign spawn      = tick_run && (cooldown == '0) && any_free;
    assign spawn_full = spawn_pos_full(rng);
    assign spawn_pos  = spawn_full[W-1:0];
    assign cd_reload  = CD_W'(MIN_GAP) + {1'b0, rng[3:0]};
    assign sched_state = state;

    always_comb begin
        any_free = 1'b0;
        free_idx = 2'd0;
        for (int i = NSLOTS - 1; i >= 0; i--) begin
            if (!obj_valid[i]) begin
                any_free = 1'b1;
                free_idx = 2'(i);
            end
        end
    end

    for (genvar g = 0; g < NSLOTS; g++) begin : g_slot
        bg_slot #(
            .W     (W),
            .SPEED (SPEED)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (start_run),
            .scroll   (tick_run),
            .load     (spawn && (free_idx == 2'(g))),
            .load_pos (spawn_pos),
            .pos      (obj_pos[g*W +: W]),
            .valid    (obj_valid[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cooldown    <= '0;
            spawn_pulse <= 1'b0;
        end else begin
            spawn_pulse <= spawn;

            case (state)
                ST_IDLE:   if (game_start) state <= ST_RUN;
                ST_RUN:    if (game_over)  state <= ST_FROZEN;
                ST_FROZEN: if (game_start) state <= ST_RUN;
                default:   state <= ST_IDLE;
            endcase

            // With every slot busy the cooldown parks at zero until one frees up.
            if (start_run) begin
                cooldown <= CD_W'(MIN_GAP);
            end else if (tick_run) begin
                if (cooldown != '0) begin
                    cooldown <= cooldown - 1'b1;
                end else if (any_free) begin
                    cooldown <= cd_reload;
                end
            end
        end
    end

endmodule
